// File: rtl/i2c_master_seq.sv
// Multi-byte I2C master sequencer: START, 7-bit address + R/W, N data bytes with ACK
// handling, STOP. Control advances on SCL rising edges; pad drives update on falling edges.
module i2c_master_seq #(
   parameter int LEN_W     = 4,
   parameter int ADDR_W    = 7,
   parameter bit NACK_LAST = 1'b1
) (
   input  logic              i2c_scl_in,
   input  logic              resetN,
   input  logic              en,
   input  logic              rw,
   input  logic [ADDR_W-1:0] dev_addr,
   input  logic [LEN_W-1:0]  len,
   input  logic [7:0]        tx_data,
   input  logic              SDA_in,
   output logic              SDA_out,
   output logic              i2c_write_en,
   output logic              i2c_scl_en,
   output logic              tx_rd,
   output logic [7:0]        rx_data,
   output logic              rx_valid,
   output logic              busy,
   output logic              done,
   output logic              nack_err,
   output logic [3:0]        state,
   output logic [2:0]        count
);

   if (ADDR_W != 7) begin : g_bad_addr_w
      $error("i2c_master_seq: ADDR_W must be 7");
   end

   typedef enum logic [3:0] {
      S_IDLE       = 4'd0,
      S_START      = 4'd1,
      S_ADDRESS    = 4'd2,
      S_READ_ACK   = 4'd3,
      S_WRITE_DATA = 4'd4,
      S_READ_ACK2  = 4'd5,
      S_READ_DATA  = 4'd6,
      S_WRITE_ACK2 = 4'd7,
      S_STOP       = 4'd8
   } state_t;

   state_t           r_state, w_state_nx;
   logic [2:0]       r_count, w_count_nx;
   logic [LEN_W-1:0] r_bytes_left, w_bl_nx, w_bl_dec;
   logic [7:0]       r_shift, w_shift_nx;
   logic             r_rw, w_rw_nx;
   logic [7:0]       r_rx_data, w_rx_data_nx;
   logic             r_tx_rd, w_tx_rd_nx;
   logic             r_rx_valid, w_rx_valid_nx;
   logic             r_done, w_done_nx;
   logic             r_nack_err, w_nack_nx;
   logic             r_sda_out, w_sda_nx;
   logic             r_write_en, w_write_en_nx;
   logic             r_scl_en, w_scl_en_nx;

   // Saturating decrement so a stray extra decrement can never wrap the byte count
   assign w_bl_dec = (r_bytes_left != '0) ? r_bytes_left - 1'b1 : '0;

   always_comb begin
      w_state_nx    = r_state;
      w_count_nx    = r_count;
      w_bl_nx       = r_bytes_left;
      w_shift_nx    = r_shift;
      w_rw_nx       = r_rw;
      w_rx_data_nx  = r_rx_data;
      w_tx_rd_nx    = 1'b0;
      w_rx_valid_nx = 1'b0;
      w_done_nx     = 1'b0;
      w_nack_nx     = r_nack_err;
      case (r_state)
         S_IDLE: begin
            if (en) begin
               w_shift_nx = {dev_addr, rw};
               w_rw_nx    = rw;
               w_bl_nx    = len;
               w_nack_nx  = 1'b0;
               w_state_nx = S_START;
            end
         end
         S_START: begin
            w_count_nx = 3'd7;
            w_state_nx = S_ADDRESS;
         end
         S_ADDRESS, S_WRITE_DATA: begin
            w_shift_nx = {r_shift[6:0], 1'b0};
            w_count_nx = r_count - 3'd1;
            if (r_count == 3'd0) begin
               w_state_nx = (r_state == S_ADDRESS) ? S_READ_ACK : S_READ_ACK2;
            end
         end
         S_READ_ACK: begin
            if (SDA_in) begin
               w_nack_nx  = 1'b1;
               w_state_nx = S_STOP;
            end else if (r_bytes_left == '0) begin
               w_state_nx = S_STOP;
            end else if (!r_rw) begin
               w_tx_rd_nx = 1'b1;
               w_shift_nx = tx_data;
               w_count_nx = 3'd7;
               w_state_nx = S_WRITE_DATA;
            end else begin
               w_count_nx = 3'd7;
               w_state_nx = S_READ_DATA;
            end
         end
         S_READ_ACK2: begin
            w_bl_nx = w_bl_dec;
            if (SDA_in) begin
               w_nack_nx  = 1'b1;
               w_state_nx = S_STOP;
            end else if (w_bl_dec != '0) begin
               w_tx_rd_nx = 1'b1;
               w_shift_nx = tx_data;
               w_count_nx = 3'd7;
               w_state_nx = S_WRITE_DATA;
            end else begin
               w_state_nx = S_STOP;
            end
         end
         S_READ_DATA: begin
            w_shift_nx = {r_shift[6:0], SDA_in};
            w_count_nx = r_count - 3'd1;
            if (r_count == 3'd0) begin
               w_rx_data_nx  = {r_shift[6:0], SDA_in};
               w_rx_valid_nx = 1'b1;
               w_bl_nx       = w_bl_dec;
               w_state_nx    = S_WRITE_ACK2;
            end
         end
         S_WRITE_ACK2: begin
            if (r_bytes_left != '0) begin
               w_count_nx = 3'd7;
               w_state_nx = S_READ_DATA;
            end else begin
               w_state_nx = S_STOP;
            end
         end
         S_STOP: begin
            w_done_nx  = 1'b1;
            w_state_nx = S_IDLE;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge i2c_scl_in or negedge resetN) begin
      if (!resetN) begin
         r_state      <= S_IDLE;
         r_count      <= 3'd0;
         r_bytes_left <= '0;
         r_shift      <= 8'd0;
         r_rw         <= 1'b0;
         r_rx_data    <= 8'd0;
         r_tx_rd      <= 1'b0;
         r_rx_valid   <= 1'b0;
         r_done       <= 1'b0;
         r_nack_err   <= 1'b0;
      end else begin
         r_state      <= w_state_nx;
         r_count      <= w_count_nx;
         r_bytes_left <= w_bl_nx;
         r_shift      <= w_shift_nx;
         r_rw         <= w_rw_nx;
         r_rx_data    <= w_rx_data_nx;
         r_tx_rd      <= w_tx_rd_nx;
         r_rx_valid   <= w_rx_valid_nx;
         r_done       <= w_done_nx;
         r_nack_err   <= w_nack_nx;
      end
   end

   // Pad controls decoded from the state entered at the last rising edge
   always_comb begin
      w_sda_nx      = 1'b1;
      w_write_en_nx = 1'b1;
      w_scl_en_nx   = 1'b1;
      case (r_state)
         S_IDLE:                    w_scl_en_nx = 1'b0;
         S_START, S_STOP: begin
            w_sda_nx    = 1'b0;
            w_scl_en_nx = 1'b0;
         end
         S_ADDRESS, S_WRITE_DATA:   w_sda_nx = r_shift[7];
         S_READ_ACK, S_READ_ACK2,
         S_READ_DATA:               w_write_en_nx = 1'b0;
         S_WRITE_ACK2:              w_sda_nx = NACK_LAST && (r_bytes_left == '0);
         default:                   w_scl_en_nx = 1'b0;
      endcase
   end

   always_ff @(negedge i2c_scl_in or negedge resetN) begin
      if (!resetN) begin
         r_sda_out  <= 1'b1;
         r_write_en <= 1'b1;
         r_scl_en   <= 1'b0;
      end else begin
         r_sda_out  <= w_sda_nx;
         r_write_en <= w_write_en_nx;
         r_scl_en   <= w_scl_en_nx;
      end
   end

   assign SDA_out      = r_sda_out;
   assign i2c_write_en = r_write_en;
   assign i2c_scl_en   = r_scl_en;
   assign tx_rd        = r_tx_rd;
   assign rx_data      = r_rx_data;
   assign rx_valid     = r_rx_valid;
   assign done         = r_done;
   assign nack_err     = r_nack_err;
   assign busy         = (r_state != S_IDLE);
   assign state        = r_state;
   assign count        = r_count;

endmodule

// File: tb/tb_i2c_master_seq.sv
// Bench for i2c_master_seq: a frame-level I2C model builds the expected bus bit stream and
// slave responses per transaction; directed cases plus randomized transactions.
module tb_i2c_master_seq;
   localparam int LEN_W = 4;

   logic             clk = 1'b0;
   logic             resetN = 1'b0;
   logic             en = 1'b0;
   logic             rw = 1'b0;
   logic [6:0]       dev_addr = 7'd0;
   logic [LEN_W-1:0] len = '0;
   logic [7:0]       tx_data = 8'd0;
   logic             SDA_in = 1'b1;
   logic             SDA_out, i2c_write_en, i2c_scl_en, tx_rd, rx_valid, busy, done, nack_err;
   logic [7:0]       rx_data;
   logic [3:0]       state;
   logic [2:0]       count;

   i2c_master_seq #(.LEN_W(LEN_W), .ADDR_W(7), .NACK_LAST(1'b1)) dut (
      .i2c_scl_in(clk), .resetN(resetN), .en(en), .rw(rw), .dev_addr(dev_addr),
      .len(len), .tx_data(tx_data), .SDA_in(SDA_in), .SDA_out(SDA_out),
      .i2c_write_en(i2c_write_en), .i2c_scl_en(i2c_scl_en), .tx_rd(tx_rd),
      .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
      .nack_err(nack_err), .state(state), .count(count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   // Sample point: mid SCL-low, after both edges have settled
   task automatic tick();
      @(posedge clk);
      #7;
   endtask

   // Frame model: per bus cycle {scl_en, write_en, sda} plus what the slave drives
   logic [2:0] exp_bus_q[$];
   logic       slv_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] data_arr[16];
   int         exp_txrd;
   logic       exp_nack;

   task automatic push_bit(input logic scl, input logic we, input logic sda, input logic slv);
      exp_bus_q.push_back({scl, we, sda});
      slv_q.push_back(slv);
   endtask

   task automatic build(input logic t_rw, input logic [6:0] a, input int n,
                        input logic a_ack, input int nack_at);
      logic [7:0] ab;
      exp_bus_q.delete();
      slv_q.delete();
      exp_q.delete();
      exp_txrd = 0;
      exp_nack = 1'b0;
      ab = {a, t_rw};
      push_bit(1'b0, 1'b1, 1'b0, 1'b1);
      for (int i = 7; i >= 0; i--) push_bit(1'b1, 1'b1, ab[i], 1'b1);
      push_bit(1'b1, 1'b0, 1'b0, !a_ack);
      if (!a_ack) begin
         exp_nack = 1'b1;
      end else if (n > 0) begin
         for (int b = 0; b < n; b++) begin
            if (!t_rw) begin
               exp_txrd++;
               for (int i = 7; i >= 0; i--) push_bit(1'b1, 1'b1, data_arr[b][i], 1'b1);
               push_bit(1'b1, 1'b0, 1'b0, b == nack_at);
               if (b == nack_at) begin
                  exp_nack = 1'b1;
                  break;
               end
            end else begin
               for (int i = 7; i >= 0; i--) push_bit(1'b1, 1'b0, 1'b0, data_arr[b][i]);
               push_bit(1'b1, 1'b1, b == n - 1, 1'b1);
               exp_q.push_back(data_arr[b]);
            end
         end
      end
      push_bit(1'b0, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic run_txn(input logic t_rw, input logic [6:0] a, input int n, input int abort_at);
      int         ntx;
      int         tx_idx;
      logic [2:0] bus;
      logic [7:0] got_q[$];
      ntx      = 0;
      tx_idx   = 0;
      rw       = t_rw;
      dev_addr = a;
      len      = LEN_W'(n);
      tx_data  = data_arr[0];
      en       = 1'b1;
      tick();
      for (int i = 0; i < exp_bus_q.size(); i++) begin
         if (i == 0) begin
            chk("start_state", state, 1);
            chk("nack_clr", nack_err, 0);
         end
         if (i == 1) chk("addr_count", count, 7);
         if (i == 2) en = 1'b0;
         if (i == abort_at) begin
            resetN = 1'b0;
            return;
         end
         bus = exp_bus_q[i];
         chk($sformatf("bus%0d", i), {busy, i2c_scl_en, i2c_write_en, i2c_write_en & SDA_out},
             {1'b1, bus[2], bus[1], bus[1] & bus[0]});
         if (tx_rd) begin
            ntx++;
            if (tx_idx < 15) tx_idx++;
            tx_data = data_arr[tx_idx];
         end
         if (rx_valid) got_q.push_back(rx_data);
         SDA_in = slv_q[i];
         tick();
      end
      SDA_in = 1'b1;
      chk("done", done, 1);
      chk("idle_state", state, 0);
      chk("idle_bus", {busy, i2c_scl_en, i2c_write_en, SDA_out}, 4'b0011);
      chk("nack_err", nack_err, exp_nack);
      chk("tx_rd_cnt", ntx, exp_txrd);
      chk("rx_cnt", got_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
         chk($sformatf("rx_byte%0d", k), got_q[k], exp_q[k]);
      tick();
      chk("done_pulse", done, 0);
      chk("nack_sticky", nack_err, exp_nack);
   endtask

   initial begin
      repeat (2) tick();
      chk("rst_state", state, 0);
      chk("rst_count", count, 0);
      chk("rst_bus", {i2c_scl_en, i2c_write_en, SDA_out}, 3'b011);
      chk("rst_flags", {tx_rd, rx_valid, done, nack_err, busy}, 0);
      chk("rst_rx", rx_data, 0);
      resetN = 1'b1;
      tick();

      // Write two bytes, all ACKed: 29 bus cycles to done
      data_arr[0] = 8'hA5; data_arr[1] = 8'h3C;
      build(1'b0, 7'h50, 2, 1'b1, -1);
      chk("len2_cycles", exp_bus_q.size(), 29);
      run_txn(1'b0, 7'h50, 2, -1);

      // Read three bytes, ACK, ACK, NACK
      data_arr[0] = 8'h11; data_arr[1] = 8'h22; data_arr[2] = 8'h33;
      build(1'b1, 7'h51, 3, 1'b1, -1);
      run_txn(1'b1, 7'h51, 3, -1);

      // Address NACK
      build(1'b0, 7'h2A, 2, 1'b0, -1);
      run_txn(1'b0, 7'h2A, 2, -1);

      // Data NACK on the second of three bytes; next start clears nack_err
      data_arr[0] = 8'h01; data_arr[1] = 8'h02; data_arr[2] = 8'h03;
      build(1'b0, 7'h33, 3, 1'b1, 1);
      run_txn(1'b0, 7'h33, 3, -1);

      // Zero-length transfer: 11 cycles
      build(1'b0, 7'h10, 0, 1'b1, -1);
      chk("len0_cycles", exp_bus_q.size(), 11);
      run_txn(1'b0, 7'h10, 0, -1);

      // Maximum length read
      for (int b = 0; b < 16; b++) data_arr[b] = 8'($urandom);
      build(1'b1, 7'h7F, 15, 1'b1, -1);
      run_txn(1'b1, 7'h7F, 15, -1);

      // Reset in the middle of READ_DATA, then a start on the first edge after release
      data_arr[0] = 8'h11; data_arr[1] = 8'h22; data_arr[2] = 8'h33;
      build(1'b1, 7'h51, 3, 1'b1, -1);
      run_txn(1'b1, 7'h51, 3, 14);
      #1;
      chk("mid_rst_state", state, 0);
      chk("mid_rst_bus", {busy, i2c_scl_en, i2c_write_en, SDA_out}, 4'b0011);
      chk("mid_rst_flags", {tx_rd, rx_valid, done, nack_err}, 0);
      chk("mid_rst_count", count, 0);
      chk("mid_rst_rx", rx_data, 0);
      #1;
      resetN = 1'b1;
      SDA_in = 1'b1;
      data_arr[0] = 8'h5A; data_arr[1] = 8'hC3;
      build(1'b0, 7'h44, 2, 1'b1, -1);
      run_txn(1'b0, 7'h44, 2, -1);

      // Randomized transactions
      for (int t = 0; t < 40; t++) begin
         logic       r_rw_t;
         logic [6:0] r_a;
         int         r_n;
         logic       r_ack;
         int         r_nk;
         r_rw_t = 1'($urandom);
         r_a    = 7'($urandom);
         r_n    = $urandom_range(0, 15);
         r_ack  = ($urandom_range(0, 9) != 0);
         r_nk   = (!r_rw_t && $urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : -1;
         for (int b = 0; b < 16; b++) data_arr[b] = 8'($urandom);
         build(r_rw_t, r_a, r_n, r_ack, r_nk);
         run_txn(r_rw_t, r_a, r_n, -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
